// File: rtl/bcd_convert_arbiter_if.sv
// Request/ack bundle between two display requesters and the shared BCD conversion engine.
interface bcd_convert_arbiter_if #(
  parameter int unsigned SIZE = 8
);
  logic            req0;
  logic [SIZE-1:0] bin0;
  logic            ack0;
  logic            req1;
  logic [SIZE-1:0] bin1;
  logic            ack1;
  logic            busy;
  logic            grant_id;
  logic [3:0]      ones;
  logic [3:0]      tens;
  logic [3:0]      hundreds;

  modport master (
    output req0, bin0, req1, bin1,
    input  ack0, ack1, busy, grant_id, ones, tens, hundreds
  );

  modport slave (
    input  req0, bin0, req1, bin1,
    output ack0, ack1, busy, grant_id, ones, tens, hundreds
  );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// One sequential double-dabble binary-to-BCD engine shared round-robin between two requesters.
// Operand is captured at grant, converted over SIZE shift cycles, result held until the next completion.
module bcd_convert_arbiter #(
  parameter int unsigned SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_convert_arbiter_if.slave   bus
);
  localparam int unsigned SR_W  = 20;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned PAD_W = OP_W - SIZE;
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       hundreds_q, hundreds_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;

  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shift;
  logic             any_req;
  logic             pick;
  logic [SIZE-1:0]  bin_pick;
  logic [OP_W-1:0]  operand;

  // One double-dabble iteration: add-3 on each BCD nibble >= 5, then shift left.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8 + 4*i +: 4] >= 4'd5) begin
        sr_adj[8 + 4*i +: 4] = sr_q[8 + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Round-robin pick: on a tie the requester that did not win last time is served.
  always_comb begin
    any_req  = bus.req0 | bus.req1;
    pick     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
    bin_pick = pick ? bus.bin1 : bus.bin0;
    operand  = OP_W'(bin_pick) << PAD_W;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    last_d     = last_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SHIFT;
          sr_d    = {12'd0, operand};
          cnt_d   = '0;
          grant_d = pick;
          last_d  = pick;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SIZE - 1)) begin
          state_d    = DONE;
          ones_d     = sr_shift[11:8];
          tens_d     = sr_shift[15:12];
          hundreds_d = sr_shift[19:16];
          ack0_d     = ~grant_q;
          ack1_d     = grant_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 4'd0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.ones     = ones_q;
  assign bus.tens     = tens_q;
  assign bus.hundreds = hundreds_q;
endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
- Shares one sequential shift-add-3 (double-dabble) binary-to-BCD engine between two requesters.
- Typical requesters are a switch-value display path and a counter display path feeding the 7-segment scanner.
- Round-robin arbitration, req/ack handshake, one conversion in flight at a time.
- Results are registered and held until the next conversion completes.

Parameters:
- SIZE, 8, operand width in bits; legal range 4 to 8; maximum value 255 fits in hundreds/tens/ones.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 conversion request, held high until ack0
- bin0  input  SIZE  requester 0 operand
- ack0  output  1  one-cycle pulse: requester 0 result valid on ones/tens/hundreds
- req1  input  1  requester 1 conversion request, held high until ack1
- bin1  input  SIZE  requester 1 operand
- ack1  output  1  one-cycle pulse: requester 1 result valid
- busy  output  1  high while a conversion is in progress (states SHIFT and DONE)
- grant_id  output  1  requester owning the current or most recent conversion
- ones  output  4  BCD ones digit, registered
- tens  output  4  BCD tens digit, registered
- hundreds  output  4  BCD hundreds digit, registered

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State = IDLE.
  - ack0 = ack1 = busy = 0; grant_id = 0; ones = tens = hundreds = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Any in-flight conversion is abandoned and no ack is issued.
- Internal datapath:
  - 20-bit shift register sr; bits [7:0] hold the operand, left-justified as {bin, (8-SIZE) zeros}; nibbles [11:8], [15:12] and [19:16] are the BCD digits.
  - Iteration counter cnt, width ceil(log2(SIZE+1)).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On grant, at the same edge: sr[19:8] = 0; sr[7:0] = {bin_granted, zero pad}; cnt = 0; grant_id = granted; last_grant = granted; next state = SHIFT.
  - The operand is sampled only at the grant edge. Later changes on bin0/bin1 have no effect on this conversion.
- SHIFT, once per cycle:
  - For each of the three nibbles independently: if the nibble is >= 5, add 3 (4-bit add, no carry into the next nibble).
  - Then shift the whole register left by 1.
  - cnt increments by 1.
  - When cnt reaches SIZE-1 on this edge (the SIZE-th iteration), next state = DONE.
  - At that same edge, ones/tens/hundreds are loaded from the post-shift sr nibbles [11:8], [15:12], [19:16].
- DONE, for exactly one cycle:
  - ack[grant_id] = 1; the other ack = 0.
  - Next state = IDLE unconditionally.
  - At least one IDLE cycle separates conversions. Requesters must drop req on the cycle after ack; a req still high in the IDLE cycle is treated as a new request.
- Latency: the grant edge is edge 0. The SHIFT edges are edges 1..SIZE. DONE/ack is visible in the cycle following edge SIZE, i.e. ack is high SIZE+1 cycles after the grant edge. Period for back-to-back service is SIZE+2 cycles.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- Digit outputs change only at the SHIFT-to-DONE transition or on reset; otherwise they hold.
- grant_id changes only at a grant edge.
- Boundary conditions:
  - req dropped mid-conversion: the conversion completes and the ack still pulses.
  - New requests during busy: ignored until IDLE; no queueing beyond the req levels.
  - Operand 0: all digits 0.
  - Operand max (2^SIZE - 1): correct BCD result.
  - Single requester held continuously: served repeatedly. Fairness applies only on ties.
- Results:
  - hundreds is never > 2 and all digits are always <= 9 for every legal SIZE.
  - Any other result is a design error; the bench asserts on it.

Test Plan:
- SIZE=8, reset, req0=1 bin0=255 at grant edge 0 -> ack0 high in the cycle after edge 8; hundreds=2, tens=5, ones=5; grant_id=0; busy high for 9 cycles.
- SIZE=8, req0 and req1 raised together (bin0=123, bin1=45), each dropped after its ack:
  - First ack0 with 1/2/3.
  - After 1 IDLE cycle, ack1 with 0/4/5.
  - Raise both again -> requester 0 wins (last_grant=1).
  - Raise both again -> requester 1 wins.
- SIZE=8, grant bin0=200, then change bin0 to 7 and drop req0 on edge 3 -> ack0 still pulses with 2/0/0.
- SIZE=8, reset asserted on edge 4 of SHIFT -> next cycle state IDLE, busy=0, digits 0, no ack0/ack1 pulse ever for that request.
- SIZE=4, req1 bin1=15 -> ack1 after edge 4 with 0/1/5. Then bin1=0 -> 0/0/0.
- SIZE=8, exhaustive sweep 0..255 on alternating requesters -> every result matches the integer hundreds/tens/ones of the operand; the ack goes to the requester matching grant_id.
